// File: rtl/lcd_hex_display_ctrl_if.sv
// Host-side and LCD-pin signal bundle for lcd_hex_display_ctrl.
// master = value source / pin consumer, slave = the controller.
interface lcd_hex_display_ctrl_if;
   logic [31:0] value;
   logic        update;
   logic        ready;
   logic        busy;
   logic [7:0]  lcd_data;
   logic        lcd_rs;
   logic        lcd_rw;
   logic        lcd_en;

   modport master (
      output value, update,
      input  ready, busy, lcd_data, lcd_rs, lcd_rw, lcd_en
   );

   modport slave (
      input  value, update,
      output ready, busy, lcd_data, lcd_rs, lcd_rw, lcd_en
   );
endinterface

// File: rtl/lcd_hex_display_ctrl.sv
// HD44780 8-bit write-only sequencer: power-up init, then redraws line 1 with 8 hex digits.
// Optional macro LCD_HEX_PREFIX_EN adds a "0x" prefix before the digits.
module lcd_hex_display_ctrl #(
   parameter int unsigned PWRUP_CYC    = 750000,
   parameter int unsigned EN_HIGH_CYC  = 12,
   parameter int unsigned CMD_WAIT_CYC = 2000,
   parameter int unsigned CLR_WAIT_CYC = 82000
) (
   input logic             clk,
   input logic             rst,
   lcd_hex_display_ctrl_if.slave bus
);

`ifdef LCD_HEX_PREFIX_EN
   localparam logic [3:0] FRAME_LEN = 4'd11;
   localparam logic [3:0] DIGIT0    = 4'd3;
`else
   localparam logic [3:0] FRAME_LEN = 4'd9;
   localparam logic [3:0] DIGIT0    = 4'd1;
`endif

   localparam int unsigned MAX_AB  = (PWRUP_CYC > EN_HIGH_CYC) ? PWRUP_CYC : EN_HIGH_CYC;
   localparam int unsigned MAX_CD  = (CMD_WAIT_CYC > CLR_WAIT_CYC) ? CMD_WAIT_CYC : CLR_WAIT_CYC;
   localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWRUP_CYC - 1);
   localparam logic [CNT_W-1:0] EN_LAST  = CNT_W'(EN_HIGH_CYC - 1);
   localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_WAIT_CYC - 1);

   typedef enum logic [2:0] {
      S_PWRUP, S_SETUP, S_EN_HI, S_HOLD, S_WAIT, S_IDLE
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       idx;
   logic             in_frame;
   logic             pending;
   logic [31:0]      pend_val;
   logic [31:0]      shreg;
   logic [7:0]       data_q;
   logic             rs_q;
   logic             en_q;
   logic             ready_q;
   logic             busy_q;

   logic [3:0]       nidx;
   logic [7:0]       nxt_byte;
   logic             nxt_rs;
   logic             nxt_done;
   logic             nxt_digit;
   logic [CNT_W-1:0] wait_last;

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   // Init and frame share one write engine; idx/in_frame pick the byte after the current one.
   always_comb begin
      nidx      = idx + 4'd1;
      nxt_byte  = '0;
      nxt_rs    = 1'b0;
      nxt_done  = 1'b0;
      nxt_digit = 1'b0;
      if (in_frame) begin
         nxt_done = (nidx == FRAME_LEN);
         nxt_rs   = 1'b1;
         if (nidx < DIGIT0) begin
            nxt_byte = (nidx == 4'd1) ? 8'h30 : 8'h78;
         end else begin
            nxt_byte  = hex_ascii(shreg[31:28]);
            nxt_digit = 1'b1;
         end
      end else begin
         nxt_done = (nidx == 4'd4);
         case (nidx)
            4'd1:    nxt_byte = 8'h0C;
            4'd2:    nxt_byte = 8'h01;
            default: nxt_byte = 8'h06;
         endcase
      end
      wait_last = (!rs_q && data_q == 8'h01) ? CLR_LAST : CMD_LAST;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_PWRUP;
         cnt      <= '0;
         idx      <= '0;
         in_frame <= 1'b0;
         pending  <= 1'b0;
         pend_val <= '0;
         shreg    <= '0;
         data_q   <= '0;
         rs_q     <= 1'b0;
         en_q     <= 1'b0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b1;
      end else begin
         if (bus.update && state != S_IDLE) begin
            pending  <= 1'b1;
            pend_val <= bus.value;
         end
         case (state)
            S_PWRUP: begin
               if (cnt == PWR_LAST) begin
                  cnt      <= '0;
                  idx      <= '0;
                  in_frame <= 1'b0;
                  data_q   <= 8'h38;
                  rs_q     <= 1'b0;
                  state    <= S_SETUP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_SETUP: begin
               en_q  <= 1'b1;
               cnt   <= '0;
               state <= S_EN_HI;
            end
            S_EN_HI: begin
               if (cnt == EN_LAST) begin
                  en_q  <= 1'b0;
                  state <= S_HOLD;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_HOLD: begin
               cnt   <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (cnt == wait_last) begin
                  cnt <= '0;
                  if (nxt_done) begin
                     if (!in_frame) ready_q <= 1'b1;
                     in_frame <= 1'b0;
                     busy_q   <= 1'b0;
                     state    <= S_IDLE;
                  end else begin
                     idx    <= nidx;
                     data_q <= nxt_byte;
                     rs_q   <= nxt_rs;
                     if (nxt_digit) shreg <= {shreg[27:0], 4'h0};
                     state  <= S_SETUP;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_IDLE: begin
               if (bus.update || pending) begin
                  pending  <= 1'b0;
                  shreg    <= bus.update ? bus.value : pend_val;
                  idx      <= '0;
                  in_frame <= 1'b1;
                  data_q   <= 8'h80;
                  rs_q     <= 1'b0;
                  busy_q   <= 1'b1;
                  state    <= S_SETUP;
               end
            end
            default: state <= S_PWRUP;
         endcase
      end
   end

   assign bus.lcd_data = data_q;
   assign bus.lcd_rs   = rs_q;
   assign bus.lcd_rw   = 1'b0;
   assign bus.lcd_en   = en_q;
   assign bus.ready    = ready_q;
   assign bus.busy     = busy_q;

endmodule

// File: tb/tb_lcd_hex_display_ctrl.sv
// Scoreboard bench for lcd_hex_display_ctrl: expected LCD strobes are queued by the
// stimulus and checked by a monitor that watches lcd_en.
module tb_lcd_hex_display_ctrl;

   typedef struct {
      logic       rs;
      logic [7:0] data;
      int         gap;   // expected lcd_en low cycles before this strobe, -1 = unchecked
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   lcd_hex_display_ctrl_if bus();

   lcd_hex_display_ctrl #(
      .PWRUP_CYC   (20),
      .EN_HIGH_CYC (2),
      .CMD_WAIT_CYC(5),
      .CLR_WAIT_CYC(10)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   rw_bad   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
   endtask

   task automatic push(input logic rs, input logic [7:0] data, input int gap);
      exp_t e;
      e.rs = rs; e.data = data; e.gap = gap;
      sb.push_back(e);
   endtask

   // Low time between strobes = HOLD + WAIT + SETUP = wait + 2.
   task automatic push_init();
      push(1'b0, 8'h38, -1);
      push(1'b0, 8'h0C, 7);
      push(1'b0, 8'h01, 7);
      push(1'b0, 8'h06, 12);
   endtask

   task automatic push_frame(input logic [63:0] chars);
      push(1'b0, 8'h80, -1);
`ifdef LCD_HEX_PREFIX_EN
      push(1'b1, 8'h30, 7);
      push(1'b1, 8'h78, 7);
`endif
      for (int i = 0; i < 8; i++) push(1'b1, chars[63-8*i -: 8], 7);
   endtask

   // ---------------- monitor ----------------
   logic       prev_en, prev_rs;
   logic [7:0] prev_data;
   logic [8:0] cur;
   int         hi_cnt, low_cnt;
   bit         have_fall;

   always @(negedge clk) begin
      if (rst) begin
         prev_en = 1'b0; prev_rs = 1'b0; prev_data = '0;
         hi_cnt = 0; low_cnt = 0; have_fall = 1'b0;
      end else begin
         if (bus.lcd_rw !== 1'b0) rw_bad++;
         if (bus.lcd_en && !prev_en) begin
            check("setup_stable", {bus.lcd_rs, bus.lcd_data}, {prev_rs, prev_data});
            if (sb.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_strobe: got rs=%0b data=0x%02h, expected no strobe",
                        bus.lcd_rs, bus.lcd_data);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("strobe_byte", {bus.lcd_rs, bus.lcd_data}, {e.rs, e.data});
               if (e.gap >= 0 && have_fall) check("strobe_gap", low_cnt, e.gap);
            end
            cur    = {bus.lcd_rs, bus.lcd_data};
            hi_cnt = 1;
         end else if (bus.lcd_en) begin
            hi_cnt++;
         end else if (prev_en) begin
            check("en_width", hi_cnt, 2);
            check("hold_stable", {bus.lcd_rs, bus.lcd_data}, cur);
            low_cnt   = 1;
            have_fall = 1'b1;
         end else begin
            low_cnt++;
         end
         prev_en   = bus.lcd_en;
         prev_rs   = bus.lcd_rs;
         prev_data = bus.lcd_data;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse(input logic [31:0] v);
      bus.value  = v;
      bus.update = 1'b1;
      tick();
      bus.update = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      while ((sb.size() != 0 || bus.busy) && n < budget) begin
         tick();
         n++;
      end
      check(name, (n >= budget), 1'b0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, expected finish before 1 ms");
      $fatal(1);
   end

   initial begin
      int en_seen;
      int n;
      rst        = 1'b1;
      bus.value  = '0;
      bus.update = 1'b0;
      repeat (3) tick();
      check("rst_busy", bus.busy, 1'b1);
      check("rst_ready", bus.ready, 1'b0);
      check("rst_en", bus.lcd_en, 1'b0);
      check("rst_data_rs", {bus.lcd_rs, bus.lcd_data}, 9'h000);

      // Power-up quiet period and init
      push_init();
      rst = 1'b0;
      en_seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.lcd_en) en_seen++;
      end
      check("pwrup_quiet", en_seen, 0);
      check("pwrup_ready_low", bus.ready, 1'b0);
      tick();
      check("first_en_rise", bus.lcd_en, 1'b1);
      wait_idle(300, "init_timeout");
      check("init_ready", bus.ready, 1'b1);
      check("init_busy", bus.busy, 1'b0);

      // Basic frame with latency check
      push_frame(64'h31323334_41424344);
      pulse(32'h1234ABCD);
      check("lat_en_low", bus.lcd_en, 1'b0);
      check("lat_setup_byte", {bus.lcd_rs, bus.lcd_data}, 9'h080);
      check("lat_busy", bus.busy, 1'b1);
      tick();
      check("lat_en_rise", bus.lcd_en, 1'b1);
      wait_idle(300, "frame1_timeout");
      check("frame1_busy", bus.busy, 1'b0);
      repeat (30) tick();

      // Updates while a frame is in progress: last one wins, exactly one extra frame
      push_frame(64'h30303030_30303030);
      push_frame(64'h46464646_46464646);
      pulse(32'h0000_0000);
      repeat (15) tick();
      pulse(32'hDEAD_BEEF);
      repeat (15) tick();
      pulse(32'hFFFF_FFFF);
      wait_idle(500, "pending_timeout");
      repeat (40) tick();
      check("pending_quiet_busy", bus.busy, 1'b0);

      // Update during power-up
      rst = 1'b1;
      repeat (3) tick();
      check("rst2_ready", bus.ready, 1'b0);
      push_init();
      push_frame(64'h30303030_30303046);
      rst = 1'b0;
      repeat (5) tick();
      pulse(32'h0000_000F);
      wait_idle(500, "pwrup_update_timeout");
      repeat (40) tick();
      check("pwrup_update_busy", bus.busy, 1'b0);

      // Reset during the third digit; the pending request must be discarded
      push(1'b0, 8'h80, -1);
`ifdef LCD_HEX_PREFIX_EN
      push(1'b1, 8'h30, 7);
      push(1'b1, 8'h78, 7);
`endif
      push(1'b1, 8'h31, 7);
      push(1'b1, 8'h32, 7);
      push(1'b1, 8'h33, 7);
      pulse(32'h1234_5678);
      repeat (5) tick();
      pulse(32'hAAAA_AAAA);
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      check("third_digit_timeout", (n >= 300), 1'b0);
      check("third_digit_en", bus.lcd_en, 1'b1);
      rst = 1'b1;
      #1;
      check("async_rst_en", bus.lcd_en, 1'b0);
      check("async_rst_ready", bus.ready, 1'b0);
      check("async_rst_busy", bus.busy, 1'b1);
      repeat (2) tick();
      push_init();
      rst = 1'b0;
      wait_idle(300, "reinit_timeout");
      check("reinit_ready", bus.ready, 1'b1);
      repeat (60) tick();
      check("no_pending_after_rst", bus.busy, 1'b0);
      check("sb_drained", sb.size(), 0);
      check("rw_low", rw_bad, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
